// File: rtl/stack_pkg.sv
// Shared constants for the data-stack sequencer: op codes, FSM states, size defaults.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package stack_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int STACK_BITS_DEF = 12;

    // Request codes from the control unit; PUSH and POP double as memory stackOp encodings.
    localparam logic [1:0] STACK_OP_NONE  = 2'b00;
    localparam logic [1:0] STACK_OP_PUSH  = 2'b01;
    localparam logic [1:0] STACK_OP_POP   = 2'b10;
    localparam logic [1:0] STACK_OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_HOLD   = 2'b10
    } stack_state_t;

endpackage

// File: rtl/stack_pointer_ctrl.sv
// Owns the data-stack pointer and sequences push/pop/clear into the stack memory.
// Latency: legal push/pop take 3 cycles (accept, ACCESS, HOLD); clear, no-op and rejected ops take 1.
// Backpressure: op_ready is high only in IDLE; requests are ignored while a push/pop is in flight.
module stack_pointer_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STACK_BITS = STACK_BITS_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [1:0]            op_code,
    output logic                  op_ready,
    output logic [DATA_WIDTH-1:0] stackPointer,
    output logic [1:0]            stackOp,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [DATA_WIDTH-1:0] ONE        = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] STACK_SIZE = ONE << STACK_BITS;

    stack_state_t state;
    logic [1:0]   latchedOp;

    // Occupancy flags come straight from the pointer register so they never lag it.
    assign full  = (stackPointer == STACK_SIZE);
    assign empty = (stackPointer == '0);

    // Sequencer: all outputs registered; the pointer only moves at the end of HOLD so the
    // memory sees the pre-op pointer for both the write/read edge and the output-gate cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            latchedOp    <= STACK_OP_NONE;
            stackPointer <= '0;
            stackOp      <= STACK_OP_NONE;
            op_ready     <= 1'b1;
            pop_valid    <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            STACK_OP_PUSH: begin
                                // A push while full never reaches the memory.
                                if (full) begin
                                    overflow <= 1'b1;
                                end else begin
                                    latchedOp <= STACK_OP_PUSH;
                                    stackOp   <= STACK_OP_PUSH;
                                    op_ready  <= 1'b0;
                                    state     <= ST_ACCESS;
                                end
                            end
                            STACK_OP_POP: begin
                                // A pop while empty never reaches the memory.
                                if (empty) begin
                                    underflow <= 1'b1;
                                end else begin
                                    latchedOp <= STACK_OP_POP;
                                    stackOp   <= STACK_OP_POP;
                                    op_ready  <= 1'b0;
                                    state     <= ST_ACCESS;
                                end
                            end
                            STACK_OP_CLEAR: begin
                                stackPointer <= '0;
                                overflow     <= 1'b0;
                                underflow    <= 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_ACCESS: begin
                    // Push: drop the write enable so only one write lands.
                    // Pop: keep read-enable high so the memory's output gate passes the word.
                    state <= ST_HOLD;
                    if (latchedOp == STACK_OP_POP) begin
                        stackOp   <= STACK_OP_POP;
                        pop_valid <= 1'b1;
                    end else begin
                        stackOp <= STACK_OP_NONE;
                    end
                end
                ST_HOLD: begin
                    state     <= ST_IDLE;
                    stackOp   <= STACK_OP_NONE;
                    pop_valid <= 1'b0;
                    op_ready  <= 1'b1;
                    if (latchedOp == STACK_OP_PUSH) begin
                        stackPointer <= stackPointer + ONE;
                    end else begin
                        stackPointer <= stackPointer - ONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    stackOp   <= STACK_OP_NONE;
                    pop_valid <= 1'b0;
                    op_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_pointer_ctrl.sv
// Bench for stack_pointer_ctrl with a small stack memory beside it and a LIFO reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stack_pointer_ctrl;
    import stack_pkg::*;

    localparam int DW   = 32;
    localparam int SB   = 2;
    localparam int SIZE = 4;

    logic          clock;
    logic          reset;
    logic          op_valid;
    logic [1:0]    op_code;
    logic          op_ready;
    logic [DW-1:0] stackPointer;
    logic [1:0]    stackOp;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    int nChecks = 0;
    int nFail   = 0;

    stack_pointer_ctrl #(.DATA_WIDTH(DW), .STACK_BITS(SB)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .stackPointer(stackPointer), .stackOp(stackOp),
        .pop_valid(pop_valid), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model: a queue of stacked words ----------------
    logic [31:0] dataIn;
    int          mPtr;
    int          mPhase;     // cycles left in the current push/pop: 2 = memory access, 1 = hold
    logic [1:0]  mOp;
    logic        mOver;
    logic        mUnder;
    logic [31:0] mData;
    logic [31:0] mq[$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mPtr = 0; mPhase = 0; mOver = 1'b0; mUnder = 1'b0; mOp = 2'b00;
            mq.delete();
        end else if (mPhase == 0) begin
            if (op_valid) begin
                case (op_code)
                    2'b01: if (mPtr == SIZE) mOver = 1'b1;
                           else begin mPhase = 2; mOp = 2'b01; mData = dataIn; end
                    2'b10: if (mPtr == 0) mUnder = 1'b1;
                           else begin mPhase = 2; mOp = 2'b10; end
                    2'b11: begin mPtr = 0; mOver = 1'b0; mUnder = 1'b0; mq.delete(); end
                    default: ;
                endcase
            end
        end else if (mPhase == 2) begin
            mPhase = 1;
        end else begin
            mPhase = 0;
            if (mOp == 2'b01) begin mq.push_back(mData); mPtr++; end
            else begin void'(mq.pop_back()); mPtr--; end
        end
    end

    // ---------------- stack memory: registered read, gated output ----------------
    logic [31:0]   mem [0:SIZE-1];
    logic [31:0]   rdReg;
    logic [31:0]   dataOut;
    logic [SB-1:0] wrIdx;
    logic [SB-1:0] rdIdx;
    assign wrIdx   = stackPointer[SB-1:0];
    assign rdIdx   = SB'(stackPointer - 32'd1);
    assign dataOut = (stackOp == 2'b10) ? rdReg : 32'd0;

    always @(posedge clock) begin
        if (stackOp == 2'b01) mem[wrIdx] <= mData;
        if (stackOp == 2'b10) rdReg <= mem[rdIdx];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- cycle-by-cycle comparison against the model ----------------
    logic [1:0] expOp;
    always @(negedge clock) begin
        if (!reset) begin
            expOp = (mPhase == 2) ? mOp : ((mPhase == 1 && mOp == 2'b10) ? 2'b10 : 2'b00);
            chk("op_ready",     32'(op_ready),  32'(mPhase == 0));
            chk("stackOp",      32'(stackOp),   32'(expOp));
            chk("pop_valid",    32'(pop_valid), 32'(mPhase == 1 && mOp == 2'b10));
            chk("stackPointer", stackPointer,   32'(mPtr));
            chk("full",         32'(full),      32'(mPtr == SIZE));
            chk("empty",        32'(empty),     32'(mPtr == 0));
            chk("overflow",     32'(overflow),  32'(mOver));
            chk("underflow",    32'(underflow), 32'(mUnder));
            if (mPhase == 1 && mOp == 2'b10) chk("pop_data", dataOut, mq[$]);
        end
    end

    // Present one request for one edge; returns at the following falling edge.
    task automatic issue(input logic [1:0] code, input logic [31:0] d);
        op_valid = 1'b1; op_code = code; dataIn = d;
        @(negedge clock);
        op_valid = 1'b0; op_code = 2'b00;
    endtask

    task automatic pushWord(input logic [31:0] d);
        issue(2'b01, d);
        repeat (2) @(negedge clock);
    endtask

    task automatic popExpect(input string nm, input logic [31:0] d);
        issue(2'b10, 32'd0);
        @(negedge clock);
        chk({nm, " pop_valid"}, 32'(pop_valid), 32'd1);
        chk({nm, " data"}, dataOut, d);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        op_valid = 1'b0; op_code = 2'b00; dataIn = 32'd0; reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst stackOp",   32'(stackOp),   32'd0);
        chk("rst op_ready",  32'(op_ready),  32'd1);
        chk("rst pop_valid", 32'(pop_valid), 32'd0);
        chk("rst sp",        stackPointer,   32'd0);
        chk("rst empty",     32'(empty),     32'd1);
        chk("rst full",      32'(full),      32'd0);
        chk("rst flags",     32'({overflow, underflow}), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle stackOp", 32'(stackOp), 32'd0);

        // Push then pop one word: stackOp 01,00,00,10,10
        issue(2'b01, 32'hDEADBEEF);
        chk("t1 op0", 32'(stackOp), 32'h1);
        chk("t1 sp0", stackPointer, 32'd0);
        @(negedge clock);
        chk("t1 op1", 32'(stackOp), 32'h0);
        @(negedge clock);
        chk("t1 op2", 32'(stackOp), 32'h0);
        chk("t1 sp1", stackPointer, 32'd1);
        issue(2'b10, 32'd0);
        chk("t1 op3", 32'(stackOp), 32'h2);
        chk("t1 pv3", 32'(pop_valid), 32'd0);
        @(negedge clock);
        chk("t1 op4", 32'(stackOp), 32'h2);
        chk("t1 pv4", 32'(pop_valid), 32'd1);
        chk("t1 data", dataOut, 32'hDEADBEEF);
        @(negedge clock);
        chk("t1 pv5", 32'(pop_valid), 32'd0);
        chk("t1 sp5", stackPointer, 32'd0);

        // LIFO ordering
        pushWord(32'd1); pushWord(32'd2); pushWord(32'd3);
        popExpect("lifo3", 32'd3);
        popExpect("lifo2", 32'd2);
        popExpect("lifo1", 32'd1);
        chk("lifo empty", 32'(empty), 32'd1);

        // Fill to capacity, then overflow
        for (int i = 0; i < SIZE; i++) pushWord(32'hA0 + 32'(i));
        chk("fill sp",   stackPointer, 32'd4);
        chk("fill full", 32'(full),    32'd1);
        issue(2'b01, 32'h55);
        chk("ovf flag",  32'(overflow), 32'd1);
        chk("ovf sp",    stackPointer,  32'd4);
        chk("ovf op",    32'(stackOp),  32'd0);
        chk("ovf ready", 32'(op_ready), 32'd1);
        popExpect("ovf top", 32'hA3);
        issue(2'b11, 32'd0);
        chk("clr sp",  stackPointer, 32'd0);
        chk("clr ovf", 32'(overflow), 32'd0);

        // Pop while empty, then clear
        issue(2'b10, 32'd0);
        chk("unf flag",  32'(underflow), 32'd1);
        chk("unf ready", 32'(op_ready),  32'd1);
        chk("unf op",    32'(stackOp),   32'd0);
        issue(2'b00, 32'd0);
        chk("unf sticky", 32'(underflow), 32'd1);
        issue(2'b11, 32'd0);
        chk("unf clr", 32'(underflow), 32'd0);

        // Reset during HOLD of a pop
        pushWord(32'd5); pushWord(32'd6);
        issue(2'b10, 32'd0);
        @(negedge clock);
        chk("rh pv", 32'(pop_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rh sp",    stackPointer,   32'd0);
        chk("rh pv0",   32'(pop_valid), 32'd0);
        chk("rh ready", 32'(op_ready),  32'd1);
        chk("rh op",    32'(stackOp),   32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic, requests held regardless of op_ready
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            r = int'($urandom_range(0, 15));
            op_valid = ($urandom_range(0, 3) != 0);
            op_code  = (r < 7) ? 2'b01 : (r < 13) ? 2'b10 : (r == 13) ? 2'b11 : 2'b00;
            dataIn   = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        @(negedge clock);
        op_valid = 1'b0;
        repeat (4) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
